uart_word_bridge: RTL and testbench
===================================

Name: uart_word_bridge

Overview:
- Parametrised word-to-byte bridge placed between the system register interface and the byte-level uart_rx/uart_tx engines.
- TX path: buffers whole words in an internal FIFO, then serialises each word into WORD_BYTES bytes over a valid/ready byte handshake, with selectable byte order.
- RX path: packs incoming bytes into words. An idle-timeout flushes partial frames with a byte count.
- Adds configurable width, depth and byte order, plus overflow/partial-frame reporting.

Parameters:
- WORD_BYTES, 4, bytes per word (1..8); word width W = 8*WORD_BYTES.
- FIFO_DEPTH, 8, TX word FIFO depth; power of 2, >=2.
- MSB_FIRST, 1, 1 = most significant byte sent/received first; 0 = LSB first.
- CLK_FRE, 50, system clock in MHz.
- BPS, 115200, UART bit rate.
- IDLE_BITS, 20, RX idle timeout in bit times; IDLE_CLKS = CLK_FRE*1000000/BPS*IDLE_BITS (integer, >=1).

Ports:
- sys_clk  in  1  system clock.
- rst  in  1  reset.
- tx_word  in  W  word to transmit.
- tx_word_valid  in  1  write request.
- tx_word_ready  out  1  FIFO not full.
- tx_level  out  clog2(FIFO_DEPTH)+1  words held in FIFO, including the word being serialised.
- tx_overflow  out  1  sticky: write attempted while full.
- tx_byte  out  8  byte to uart_tx.
- tx_byte_valid  out  1  byte valid.
- tx_byte_ready  in  1  uart_tx accepts the byte.
- rx_byte  in  8  byte from uart_rx.
- rx_byte_valid  in  1  one-cycle strobe per received byte.
- rx_word  out  W  assembled word.
- rx_word_valid  out  1  one-cycle pulse.
- rx_word_nbytes  out  clog2(WORD_BYTES)+1  valid bytes in rx_word.
- rx_partial  out  1  rx_word produced by timeout, with fewer than WORD_BYTES bytes.

Interface rules:
- One clock, sys_clk. Reset rst is asynchronous and active-high.
- All outputs are registered.

Behaviour:

Reset:
- tx_word_ready=1, tx_level=0, tx_overflow=0, tx_byte=0, tx_byte_valid=0.
- rx_word=0, rx_word_valid=0, rx_word_nbytes=0, rx_partial=0.
- FIFO empty, all counters 0, TX FSM in IDLE.
- Reset mid-operation aborts any word in flight; no partial byte stream resumes after reset.

TX FIFO:
- A write is accepted when tx_word_valid && tx_word_ready.
- A write while full is dropped and sets tx_overflow; only reset clears it.
- A simultaneous write and pop while full is not allowed: tx_word_ready is low when full regardless of a pop.
- tx_level counts increments on accepted writes and decrements when the last byte of a word handshakes.

TX FSM:
- IDLE: if FIFO not empty -> LOAD.
- LOAD: copy head word into the shift register, byte index k=0 -> SEND. The FIFO entry is freed at the last-byte handshake, not at load.
- SEND: tx_byte_valid=1 with tx_byte = byte k in the configured order.
  - On tx_byte_ready, k++.
  - If k reaches WORD_BYTES-1 at handshake: pop the FIFO, then -> LOAD if more words remain, else -> IDLE.
- tx_byte holds stable while valid && !ready.
- Latency: first tx_byte_valid appears 2 cycles after an accepted write into an empty FIFO.

RX packer:
- Each rx_byte_valid shifts the byte into the accumulator in the configured order, increments the count and clears the idle counter.
- Count reaching WORD_BYTES: the next cycle outputs rx_word_valid=1, rx_word_nbytes=WORD_BYTES, rx_partial=0, and the count returns to 0.
- Idle counter increments while count>0 and no byte arrives.
  - At IDLE_CLKS: emit the partial word with rx_partial=1 and rx_word_nbytes=count, then clear the count.
  - Unfilled bytes are zero; valid bytes are right-justified for MSB_FIRST=1 and left in the low positions for MSB_FIRST=0.
- A byte arriving in the same cycle the timeout expires takes priority; no flush occurs.
- The idle counter does not run while count==0.
- There is no backpressure: rx_word and the flags hold until the next emission, and rx_word_valid is a single-cycle pulse.

Decomposition:
- Package uart_pkg holds:
  - clog2 function.
  - IDLE_CLKS derivation function.
  - TX FSM state enum: IDLE, LOAD, SEND.
- One sub-module, uart_word_fifo: synchronous FIFO with parameters width/depth and ports push, pop, full, empty, level.
- The packer and serialiser stay inline.

Test Plan:
- WORD_BYTES=4, MSB_FIRST=1; write 0x11223344 with tx_byte_ready tied 1 -> bytes 0x11,0x22,0x33,0x44 on consecutive cycles; first valid 2 cycles after the write; tx_level returns to 0.
- MSB_FIRST=0, WORD_BYTES=2; write 0xABCD, and hold tx_byte_ready low for 5 cycles -> tx_byte=0xCD stable throughout, then 0xAB.
- With tx_byte_ready=0, write 9 words into a depth-8 FIFO -> tx_word_ready=0 after the 8th write; 9th dropped; tx_overflow=1; tx_level=8.
- RX: drive bytes 0xDE,0xAD,0xBE,0xEF at 10-cycle spacing -> one pulse, rx_word=0xDEADBEEF, nbytes=4, rx_partial=0.
- RX: drive 0x12,0x34, then idle IDLE_CLKS -> rx_word=0x00001234, nbytes=2, rx_partial=1. Repeat with a third byte arriving exactly at expiry -> no flush, count=3.
- Assert rst mid-SEND, after byte 1 of 4 -> outputs at reset values immediately; after release, no further bytes of that word are sent.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared helpers for the UART word bridge: width math, idle-timeout derivation, TX FSM states.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} tx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

  // Integer division happens before the multiply so the result matches a
  // whole number of clocks per bit, scaled by the idle bit count.
  function automatic int idle_clks(input int clk_fre, input int bps, input int idle_bits);
    longint t;
    t = (longint'(clk_fre) * 64'd1000000) / longint'(bps) * longint'(idle_bits);
    if (t < 64'd1) t = 64'd1;
    return int'(t);
  endfunction

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous word FIFO with registered full/empty/level; head word is read combinationally.
// One-cycle write latency to empty deassertion; pushes while full are ignored.
module uart_word_fifo import uart_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_dat,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  level
);

  localparam int AW = clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      full_q  <= (count_d == FULL_LVL);
      empty_q <= (count_d == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_dat;
  end

  assign rd_dat = mem_q[rd_ptr_q];
  assign full   = full_q;
  assign empty  = empty_q;
  assign level  = count_q;

endmodule

// File: rtl/uart_word_bridge.sv
// Word<->byte bridge: TX FIFO + serialiser (first byte 2 cycles after write, stalls on tx_byte_ready),
// RX packer with idle-timeout flush (word 1 cycle after last byte, no backpressure).
module uart_word_bridge import uart_pkg::*; #(
  parameter int WORD_BYTES = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int MSB_FIRST  = 1,
  parameter int CLK_FRE    = 50,
  parameter int BPS        = 115200,
  parameter int IDLE_BITS  = 20
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic [8*WORD_BYTES-1:0]      tx_word,
  input  logic                         tx_word_valid,
  output logic                         tx_word_ready,
  output logic [clog2(FIFO_DEPTH):0]   tx_level,
  output logic                         tx_overflow,
  output logic [7:0]                   tx_byte,
  output logic                         tx_byte_valid,
  input  logic                         tx_byte_ready,
  input  logic [7:0]                   rx_byte,
  input  logic                         rx_byte_valid,
  output logic [8*WORD_BYTES-1:0]      rx_word,
  output logic                         rx_word_valid,
  output logic [clog2(WORD_BYTES):0]   rx_word_nbytes,
  output logic                         rx_partial
);

  localparam int W         = 8 * WORD_BYTES;
  localparam int CW        = clog2(WORD_BYTES) + 1;
  localparam int LW        = clog2(FIFO_DEPTH) + 1;
  localparam int IDLE_CLKS = idle_clks(CLK_FRE, BPS, IDLE_BITS);

  localparam logic [CW-1:0] LAST_K    = CW'(WORD_BYTES - 1);
  localparam logic [CW-1:0] FULL_N    = CW'(WORD_BYTES);
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [31:0]   IDLE_LAST = 32'(IDLE_CLKS - 1);

  function automatic logic [7:0] pick_byte(input logic [W-1:0] word, input logic [CW-1:0] k);
    int pos;
    pos = (MSB_FIRST != 0) ? (WORD_BYTES - 1 - int'(k)) : int'(k);
    return 8'(word >> (8 * pos));
  endfunction

  logic            fifo_full, fifo_empty, fifo_pop;
  logic [W-1:0]    fifo_head;
  logic [LW-1:0]   fifo_level;

  tx_state_e       state_q;
  logic [W-1:0]    word_q;
  logic [CW-1:0]   k_q;
  logic [7:0]      tx_byte_q;
  logic            tx_byte_valid_q;
  logic            tx_overflow_q;

  // Entry stays in the FIFO until its last byte leaves, so tx_level covers the word in flight.
  assign fifo_pop = (state_q == SEND) && tx_byte_ready && (k_q == LAST_K);

  uart_word_fifo #(
    .WIDTH (W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (sys_clk),
    .rst    (rst),
    .push   (tx_word_valid),
    .wr_dat (tx_word),
    .pop    (fifo_pop),
    .rd_dat (fifo_head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (fifo_level)
  );

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      word_q          <= '0;
      k_q             <= '0;
      tx_byte_q       <= '0;
      tx_byte_valid_q <= 1'b0;
      tx_overflow_q   <= 1'b0;
    end else begin
      if (tx_word_valid && fifo_full) tx_overflow_q <= 1'b1;
      case (state_q)
        IDLE: if (!fifo_empty) state_q <= LOAD;
        LOAD: begin
          word_q          <= fifo_head;
          k_q             <= '0;
          tx_byte_q       <= pick_byte(fifo_head, '0);
          tx_byte_valid_q <= 1'b1;
          state_q         <= SEND;
        end
        SEND: if (tx_byte_ready) begin
          if (k_q == LAST_K) begin
            tx_byte_valid_q <= 1'b0;
            k_q             <= '0;
            state_q         <= (fifo_level != LVL_ONE) ? LOAD : IDLE;
          end else begin
            k_q       <= k_q + 1'b1;
            tx_byte_q <= pick_byte(word_q, k_q + 1'b1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_word_ready = !fifo_full;
  assign tx_level      = fifo_level;
  assign tx_overflow   = tx_overflow_q;
  assign tx_byte       = tx_byte_q;
  assign tx_byte_valid = tx_byte_valid_q;

  logic [W-1:0]  acc_q, acc_d, acc_ins;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   idle_q, idle_d;
  logic [W-1:0]  rx_word_q, rx_word_d;
  logic          rx_word_valid_q, rx_word_valid_d;
  logic [CW-1:0] rx_nbytes_q, rx_nbytes_d;
  logic          rx_partial_q, rx_partial_d;

  always_comb begin
    if (MSB_FIRST != 0) acc_ins = (acc_q << 8) | W'(rx_byte);
    else                acc_ins = acc_q | (W'(rx_byte) << (8 * int'(cnt_q)));
  end

  // A byte landing on the expiry cycle wins over the flush.
  always_comb begin
    acc_d           = acc_q;
    cnt_d           = cnt_q;
    idle_d          = idle_q;
    rx_word_d       = rx_word_q;
    rx_word_valid_d = 1'b0;
    rx_nbytes_d     = rx_nbytes_q;
    rx_partial_d    = rx_partial_q;
    if (rx_byte_valid) begin
      idle_d = '0;
      if (cnt_q == LAST_K) begin
        rx_word_d       = acc_ins;
        rx_word_valid_d = 1'b1;
        rx_nbytes_d     = FULL_N;
        rx_partial_d    = 1'b0;
        acc_d           = '0;
        cnt_d           = '0;
      end else begin
        acc_d = acc_ins;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (cnt_q != '0) begin
      if (idle_q == IDLE_LAST) begin
        rx_word_d       = acc_q;
        rx_word_valid_d = 1'b1;
        rx_nbytes_d     = cnt_q;
        rx_partial_d    = 1'b1;
        acc_d           = '0;
        cnt_d           = '0;
        idle_d          = '0;
      end else begin
        idle_d = idle_q + 32'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      acc_q           <= '0;
      cnt_q           <= '0;
      idle_q          <= '0;
      rx_word_q       <= '0;
      rx_word_valid_q <= 1'b0;
      rx_nbytes_q     <= '0;
      rx_partial_q    <= 1'b0;
    end else begin
      acc_q           <= acc_d;
      cnt_q           <= cnt_d;
      idle_q          <= idle_d;
      rx_word_q       <= rx_word_d;
      rx_word_valid_q <= rx_word_valid_d;
      rx_nbytes_q     <= rx_nbytes_d;
      rx_partial_q    <= rx_partial_d;
    end
  end

  assign rx_word        = rx_word_q;
  assign rx_word_valid  = rx_word_valid_q;
  assign rx_word_nbytes = rx_nbytes_q;
  assign rx_partial     = rx_partial_q;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: MSB-first 4-byte instance (a_*) and LSB-first 2-byte instance (b_*).
module tb_uart_word_bridge;

  // CLK_FRE=1, BPS=250000, IDLE_BITS=4 -> 4 clocks/bit * 4 = 16 idle clocks
  localparam int IDLE_CLKS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] a_tx_word;   logic a_tx_word_valid, a_tx_word_ready;
  logic [3:0]  a_tx_level;  logic a_tx_overflow;
  logic [7:0]  a_tx_byte;   logic a_tx_byte_valid, a_tx_byte_ready;
  logic [7:0]  a_rx_byte;   logic a_rx_byte_valid;
  logic [31:0] a_rx_word;   logic a_rx_word_valid;
  logic [2:0]  a_rx_word_nbytes; logic a_rx_partial;

  logic [15:0] b_tx_word;   logic b_tx_word_valid, b_tx_word_ready;
  logic [3:0]  b_tx_level;  logic b_tx_overflow;
  logic [7:0]  b_tx_byte;   logic b_tx_byte_valid, b_tx_byte_ready;
  logic [7:0]  b_rx_byte;   logic b_rx_byte_valid;
  logic [15:0] b_rx_word;   logic b_rx_word_valid;
  logic [1:0]  b_rx_word_nbytes; logic b_rx_partial;

  int n_checks = 0;
  int n_fail   = 0;
  int a_pulses = 0;

  always @(posedge clk) if (a_rx_word_valid === 1'b1) a_pulses++;

  uart_word_bridge #(
    .WORD_BYTES(4), .FIFO_DEPTH(8), .MSB_FIRST(1), .CLK_FRE(1), .BPS(250000), .IDLE_BITS(4)
  ) dut_a (
    .sys_clk(clk), .rst(rst),
    .tx_word(a_tx_word), .tx_word_valid(a_tx_word_valid), .tx_word_ready(a_tx_word_ready),
    .tx_level(a_tx_level), .tx_overflow(a_tx_overflow),
    .tx_byte(a_tx_byte), .tx_byte_valid(a_tx_byte_valid), .tx_byte_ready(a_tx_byte_ready),
    .rx_byte(a_rx_byte), .rx_byte_valid(a_rx_byte_valid),
    .rx_word(a_rx_word), .rx_word_valid(a_rx_word_valid),
    .rx_word_nbytes(a_rx_word_nbytes), .rx_partial(a_rx_partial)
  );

  uart_word_bridge #(
    .WORD_BYTES(2), .FIFO_DEPTH(8), .MSB_FIRST(0), .CLK_FRE(1), .BPS(250000), .IDLE_BITS(4)
  ) dut_b (
    .sys_clk(clk), .rst(rst),
    .tx_word(b_tx_word), .tx_word_valid(b_tx_word_valid), .tx_word_ready(b_tx_word_ready),
    .tx_level(b_tx_level), .tx_overflow(b_tx_overflow),
    .tx_byte(b_tx_byte), .tx_byte_valid(b_tx_byte_valid), .tx_byte_ready(b_tx_byte_ready),
    .rx_byte(b_rx_byte), .rx_byte_valid(b_rx_byte_valid),
    .rx_word(b_rx_word), .rx_word_valid(b_rx_word_valid),
    .rx_word_nbytes(b_rx_word_nbytes), .rx_partial(b_rx_partial)
  );

  function automatic logic [31:0] ovf_word(input int i);
    return 32'h01020304 + 32'(i) * 32'h10101010;
  endfunction

  task automatic send_a(input logic [7:0] b);
    a_rx_byte = b; a_rx_byte_valid = 1'b1;
    @(negedge clk);
    a_rx_byte_valid = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    b_rx_byte = b; b_rx_byte_valid = 1'b1;
    @(negedge clk);
    b_rx_byte_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (a_tx_word_ready !== 1'b1) begin n_fail++; $display("FAIL reset_tx_word_ready: got %b want 1", a_tx_word_ready); end
    n_checks++; if (a_tx_level !== 4'd0) begin n_fail++; $display("FAIL reset_tx_level: got %0d want 0", a_tx_level); end
    n_checks++; if ({a_tx_overflow, a_tx_byte_valid, a_tx_byte} !== 10'd0) begin n_fail++; $display("FAIL reset_tx_out: got ovf=%b vld=%b byte=%h want 0", a_tx_overflow, a_tx_byte_valid, a_tx_byte); end
    n_checks++; if ({a_rx_word, a_rx_word_valid, a_rx_word_nbytes, a_rx_partial} !== 37'd0) begin n_fail++; $display("FAIL reset_rx_out: got word=%h vld=%b n=%0d part=%b want 0", a_rx_word, a_rx_word_valid, a_rx_word_nbytes, a_rx_partial); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_tx_msb_first;
    logic [7:0] exp_b [4];
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44};
    a_tx_byte_ready = 1'b1;
    a_tx_word = 32'h11223344; a_tx_word_valid = 1'b1;
    @(negedge clk);
    a_tx_word_valid = 1'b0;
    n_checks++; if (a_tx_level !== 4'd1) begin n_fail++; $display("FAIL msb_level_after_write: got %0d want 1", a_tx_level); end
    n_checks++; if (a_tx_byte_valid !== 1'b0) begin n_fail++; $display("FAIL msb_valid_cycle1: got %b want 0", a_tx_byte_valid); end
    @(negedge clk);
    n_checks++; if (a_tx_byte_valid !== 1'b0) begin n_fail++; $display("FAIL msb_valid_cycle2_early: got %b want 0", a_tx_byte_valid); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++;
      if (a_tx_byte_valid !== 1'b1 || a_tx_byte !== exp_b[i]) begin
        n_fail++; $display("FAIL msb_byte%0d: got vld=%b byte=%h want vld=1 byte=%h", i, a_tx_byte_valid, a_tx_byte, exp_b[i]);
      end
    end
    @(negedge clk);
    n_checks++; if (a_tx_byte_valid !== 1'b0) begin n_fail++; $display("FAIL msb_valid_after_word: got %b want 0", a_tx_byte_valid); end
    n_checks++; if (a_tx_level !== 4'd0) begin n_fail++; $display("FAIL msb_level_drained: got %0d want 0", a_tx_level); end
  endtask

  task automatic test_tx_lsb_hold;
    b_tx_byte_ready = 1'b0;
    b_tx_word = 16'hABCD; b_tx_word_valid = 1'b1;
    @(negedge clk);
    b_tx_word_valid = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (b_tx_byte_valid !== 1'b1 || b_tx_byte !== 8'hCD) begin
        n_fail++; $display("FAIL lsb_hold%0d: got vld=%b byte=%h want vld=1 byte=cd", i, b_tx_byte_valid, b_tx_byte);
      end
      if (i < 4) @(negedge clk);
    end
    b_tx_byte_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (b_tx_byte_valid !== 1'b1 || b_tx_byte !== 8'hAB) begin n_fail++; $display("FAIL lsb_second_byte: got vld=%b byte=%h want vld=1 byte=ab", b_tx_byte_valid, b_tx_byte); end
    @(negedge clk);
    n_checks++; if (b_tx_byte_valid !== 1'b0 || b_tx_level !== 4'd0) begin n_fail++; $display("FAIL lsb_done: got vld=%b level=%0d want 0 0", b_tx_byte_valid, b_tx_level); end
    b_tx_byte_ready = 1'b0;
  endtask

  task automatic test_tx_overflow;
    int nb;
    logic [7:0] exp;
    a_tx_byte_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      a_tx_word = ovf_word(i); a_tx_word_valid = 1'b1;
      @(negedge clk);
      if (i == 6) begin
        n_checks++; if (a_tx_word_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_ready_at7: got %b want 1", a_tx_word_ready); end
      end
      if (i == 7) begin
        n_checks++; if (a_tx_word_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_at8: got %b want 0", a_tx_word_ready); end
        n_checks++; if (a_tx_overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_flag_early: got %b want 0", a_tx_overflow); end
      end
    end
    a_tx_word_valid = 1'b0;
    n_checks++; if (a_tx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b want 1", a_tx_overflow); end
    n_checks++; if (a_tx_level !== 4'd8) begin n_fail++; $display("FAIL ovf_level: got %0d want 8", a_tx_level); end
    a_tx_byte_ready = 1'b1;
    nb = 0;
    for (int c = 0; c < 200 && nb < 40; c++) begin
      if (a_tx_byte_valid === 1'b1) begin
        if (nb < 32) begin
          exp = 8'(ovf_word(nb / 4) >> (8 * (3 - (nb % 4))));
          n_checks++;
          if (a_tx_byte !== exp) begin n_fail++; $display("FAIL ovf_drain_byte%0d: got %h want %h", nb, a_tx_byte, exp); end
        end
        nb++;
      end
      @(negedge clk);
    end
    n_checks++; if (nb !== 32) begin n_fail++; $display("FAIL ovf_drain_count: got %0d want 32", nb); end
    n_checks++; if (a_tx_level !== 4'd0 || a_tx_word_ready !== 1'b1) begin n_fail++; $display("FAIL ovf_drained: got level=%0d rdy=%b want 0 1", a_tx_level, a_tx_word_ready); end
    n_checks++; if (a_tx_overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", a_tx_overflow); end
  endtask

  task automatic test_rx_word;
    logic [7:0] bytes [4];
    int p0;
    bytes = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    p0 = a_pulses;
    for (int i = 0; i < 4; i++) begin
      send_a(bytes[i]);
      if (i < 3) repeat (9) @(negedge clk);
    end
    n_checks++; if (a_rx_word_valid !== 1'b1 || a_rx_word !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rx_full_word: got vld=%b word=%h want 1 deadbeef", a_rx_word_valid, a_rx_word); end
    n_checks++; if (a_rx_word_nbytes !== 3'd4 || a_rx_partial !== 1'b0) begin n_fail++; $display("FAIL rx_full_flags: got n=%0d part=%b want 4 0", a_rx_word_nbytes, a_rx_partial); end
    @(negedge clk);
    n_checks++; if (a_rx_word_valid !== 1'b0 || a_rx_word !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rx_full_pulse_hold: got vld=%b word=%h want 0 deadbeef", a_rx_word_valid, a_rx_word); end
    repeat (3) @(negedge clk);
    n_checks++; if (a_pulses - p0 !== 1) begin n_fail++; $display("FAIL rx_full_pulse_count: got %0d want 1", a_pulses - p0); end
  endtask

  task automatic test_rx_timeout;
    send_a(8'h12);
    send_a(8'h34);
    repeat (IDLE_CLKS - 1) @(negedge clk);
    n_checks++; if (a_rx_word_valid !== 1'b0) begin n_fail++; $display("FAIL rx_timeout_early: got vld=%b want 0", a_rx_word_valid); end
    @(negedge clk);
    n_checks++; if (a_rx_word_valid !== 1'b1 || a_rx_word !== 32'h00001234) begin n_fail++; $display("FAIL rx_timeout_word: got vld=%b word=%h want 1 00001234", a_rx_word_valid, a_rx_word); end
    n_checks++; if (a_rx_word_nbytes !== 3'd2 || a_rx_partial !== 1'b1) begin n_fail++; $display("FAIL rx_timeout_flags: got n=%0d part=%b want 2 1", a_rx_word_nbytes, a_rx_partial); end
  endtask

  task automatic test_rx_expiry_byte;
    int p0;
    repeat (2) @(negedge clk);
    p0 = a_pulses;
    send_a(8'h12);
    send_a(8'h34);
    repeat (IDLE_CLKS - 1) @(negedge clk);
    send_a(8'h56);
    n_checks++; if (a_rx_word_valid !== 1'b0) begin n_fail++; $display("FAIL rx_expiry_no_flush: got vld=%b want 0", a_rx_word_valid); end
    repeat (IDLE_CLKS - 1) @(negedge clk);
    n_checks++; if (a_pulses - p0 !== 0 || a_rx_word_valid !== 1'b0) begin n_fail++; $display("FAIL rx_expiry_quiet: got pulses=%0d vld=%b want 0 0", a_pulses - p0, a_rx_word_valid); end
    @(negedge clk);
    n_checks++; if (a_rx_word_valid !== 1'b1 || a_rx_word !== 32'h00123456) begin n_fail++; $display("FAIL rx_expiry_word: got vld=%b word=%h want 1 00123456", a_rx_word_valid, a_rx_word); end
    n_checks++; if (a_rx_word_nbytes !== 3'd3 || a_rx_partial !== 1'b1) begin n_fail++; $display("FAIL rx_expiry_flags: got n=%0d part=%b want 3 1", a_rx_word_nbytes, a_rx_partial); end
    repeat (3 * IDLE_CLKS) @(negedge clk);
    n_checks++; if (a_pulses - p0 !== 1) begin n_fail++; $display("FAIL rx_idle_stopped: got pulses=%0d want 1", a_pulses - p0); end
  endtask

  task automatic test_rx_lsb;
    send_b(8'h11);
    send_b(8'h22);
    n_checks++; if (b_rx_word_valid !== 1'b1 || b_rx_word !== 16'h2211) begin n_fail++; $display("FAIL rx_lsb_word: got vld=%b word=%h want 1 2211", b_rx_word_valid, b_rx_word); end
    n_checks++; if (b_rx_word_nbytes !== 2'd2 || b_rx_partial !== 1'b0) begin n_fail++; $display("FAIL rx_lsb_flags: got n=%0d part=%b want 2 0", b_rx_word_nbytes, b_rx_partial); end
  endtask

  task automatic test_reset_mid_send;
    int seen;
    a_tx_byte_ready = 1'b1;
    a_tx_word = 32'hA1B2C3D4; a_tx_word_valid = 1'b1;
    @(negedge clk);
    a_tx_word_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (a_tx_byte_valid !== 1'b1 || a_tx_byte !== 8'hB2) begin n_fail++; $display("FAIL midrst_pre_byte1: got vld=%b byte=%h want 1 b2", a_tx_byte_valid, a_tx_byte); end
    rst = 1'b1;
    #1;
    n_checks++; if ({a_tx_byte_valid, a_tx_byte, a_tx_level, a_tx_overflow} !== 14'd0) begin n_fail++; $display("FAIL midrst_tx_out: got vld=%b byte=%h level=%0d ovf=%b want 0", a_tx_byte_valid, a_tx_byte, a_tx_level, a_tx_overflow); end
    n_checks++; if (a_tx_word_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", a_tx_word_ready); end
    n_checks++; if ({a_rx_word, a_rx_word_nbytes, a_rx_partial} !== 36'd0) begin n_fail++; $display("FAIL midrst_rx_out: got word=%h n=%0d part=%b want 0", a_rx_word, a_rx_word_nbytes, a_rx_partial); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_tx_byte_valid === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0 || a_tx_level !== 4'd0) begin n_fail++; $display("FAIL midrst_no_resume: got valid_cycles=%0d level=%0d want 0 0", seen, a_tx_level); end
  endtask

  initial begin
    rst = 1'b1;
    a_tx_word = '0; a_tx_word_valid = 1'b0; a_tx_byte_ready = 1'b0;
    a_rx_byte = '0; a_rx_byte_valid = 1'b0;
    b_tx_word = '0; b_tx_word_valid = 1'b0; b_tx_byte_ready = 1'b0;
    b_rx_byte = '0; b_rx_byte_valid = 1'b0;
    test_reset();
    test_tx_msb_first();
    test_tx_lsb_hold();
    test_tx_overflow();
    test_rx_word();
    test_rx_timeout();
    test_rx_expiry_byte();
    test_rx_lsb();
    test_reset_mid_send();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
